// File: rtl/spi_frame_sched_if.sv
// rtl/spi_frame_sched_if.sv - byte-engine side of the SPI frame scheduler
interface spi_frame_sched_if;
  logic       cs_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       eng_busy;

  modport master (output cs_n, tx_valid, tx_data, input tx_ready, eng_busy);
  modport slave  (input cs_n, tx_valid, tx_data, output tx_ready, eng_busy);
endinterface

// File: rtl/spi_frame_sched.sv
// rtl/spi_frame_sched.sv - two-requester SPI frame scheduler: round-robin grant,
// chip-select lead, preamble/type header, payload streaming, drain and inter-frame gap.
module spi_frame_sched #(
  parameter int unsigned CS_LEAD   = 112,
  parameter int unsigned CS_GAP    = 256,
  parameter logic [7:0]  PREAMBLE0 = 8'hAA,
  parameter logic [7:0]  PREAMBLE1 = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [7:0]        type0,
  input  logic [7:0]        type1,
  input  logic [7:0]        len0,
  input  logic [7:0]        len1,
  input  logic [7:0]        pld0,
  input  logic [7:0]        pld1,
  output logic [1:0]        pld_rd,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              busy,
  spi_frame_sched_if.master sif
);
  typedef enum logic [2:0] {IDLE, LEAD, HDR, PLD, DRAIN, GAP} state_t;

  localparam logic [15:0] LEAD_LAST = 16'(CS_LEAD - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  type_q, type_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        gidx_q, gidx_d;
  logic        rr_q, rr_d;
  logic        cs_n_q, cs_n_d;
  logic        valid_c, hs_c, pick_c;
  logic [7:0]  data_c;

  // rr_q names the requester that wins when both ask at once.
  assign pick_c = (req == 2'b11) ? rr_q : req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hdr_idx_q <= '0;
      rem_q     <= '0;
      type_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      gidx_q    <= 1'b0;
      rr_q      <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_idx_q <= hdr_idx_d;
      rem_q     <= rem_d;
      type_q    <= type_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      cs_n_q    <= cs_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_idx_d = hdr_idx_q;
    rem_d     = rem_q;
    type_d    = type_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    cs_n_d    = cs_n_q;
    pld_rd    = '0;
    data_c    = '0;
    valid_c   = (state_q == HDR) || (state_q == PLD);
    hs_c      = valid_c && sif.tx_ready;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gidx_d  = pick_c;
          gnt_d   = pick_c ? 2'b10 : 2'b01;
          rr_d    = ~pick_c;
          type_d  = pick_c ? type1 : type0;
          rem_d   = pick_c ? len1 : len0;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          cnt_d     = '0;
          hdr_idx_d = '0;
          state_d   = HDR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HDR: begin
        unique case (hdr_idx_q)
          2'd0:    data_c = PREAMBLE0;
          2'd1:    data_c = PREAMBLE1;
          default: data_c = type_q;
        endcase
        if (hs_c) begin
          if (hdr_idx_q == 2'd2) begin
            hdr_idx_d = '0;
            state_d   = (rem_q != 8'd0) ? PLD : DRAIN;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      PLD: begin
        data_c = gidx_q ? pld1 : pld0;
        if (hs_c) begin
          pld_rd = gnt_q;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Chip select must not rise until the engine has shifted out the last bit.
        if (!sif.eng_busy) begin
          cs_n_d  = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sif.cs_n     = cs_n_q;
  assign sif.tx_valid = valid_c;
  assign sif.tx_data  = data_c;
  assign gnt          = gnt_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: doc/spi_frame_sched.md
SPI_FRAME_SCHED -- requirements
Module: spi_frame_sched

Interface
REQ-001 SHALL have parameter CS_LEAD, default 112, giving the clk cycles from cs_n falling to the first tx_valid.
REQ-002 SHALL have parameter CS_GAP, default 256, giving the minimum clk cycles cs_n stays high between frames.
REQ-003 SHALL have parameter PREAMBLE0, default 8'hAA, as header byte 0.
REQ-004 SHALL have parameter PREAMBLE1, default 8'h55, as header byte 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req, input, 2 bits: per-requester frame request, level, held until that requester's done pulse.
REQ-008 SHALL have ports type0 and type1, input, 8 bits each: frame type byte, sampled at grant.
REQ-009 SHALL have ports len0 and len1, input, 8 bits each: payload byte count 0..255, sampled at grant.
REQ-010 SHALL have ports pld0 and pld1, input, 8 bits each: current payload byte, show-ahead.
REQ-011 SHALL have port pld_rd, output, 2 bits: one-cycle pop strobe to the granted requester.
REQ-012 SHALL have port gnt, output, 2 bits: one-hot grant, held for the whole frame.
REQ-013 SHALL have port done, output, 2 bits: one-cycle pulse when that requester's frame completes.
REQ-014 SHALL have port cs_n, output, 1 bit: SPI chip select to the byte engine and pad, active low.
REQ-015 SHALL have port tx_valid, output, 1 bit: byte offered to the SPI byte engine.
REQ-016 SHALL have port tx_data, output, 8 bits: the byte offered.
REQ-017 SHALL have port tx_ready, input, 1 bit: engine accepts a byte when tx_valid and tx_ready are both high in the same cycle.
REQ-018 SHALL have port eng_busy, input, 1 bit: engine is still shifting bits.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, LEAD, HDR, PLD, DRAIN and GAP.
REQ-021 IDLE: when any req bit is high, SHALL latch the grant, type and len, set gnt, drive cs_n low, and enter LEAD on the next cycle.
REQ-022 Arbitration SHALL be round-robin: with both requests high, grant goes to the requester not granted last; the pointer after reset SHALL favour requester 0.
REQ-023 LEAD: SHALL count exactly CS_LEAD cycles with cs_n low and tx_valid low, then enter HDR.
REQ-024 HDR: SHALL offer PREAMBLE0, then PREAMBLE1, then the latched type, advancing one byte per accepted handshake; tx_valid SHALL stay high until the third byte is accepted.
REQ-025 After the header, SHALL enter PLD if the latched len is nonzero, else DRAIN.
REQ-026 PLD: tx_data SHALL equal the granted pld input; each accepted byte SHALL raise pld_rd for the granted requester in that same cycle and decrement an 8-bit remaining counter; acceptance of byte len SHALL enter DRAIN.
REQ-027 tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-028 DRAIN: tx_valid SHALL be low; the block SHALL wait for eng_busy low, then drive cs_n high, pulse done for the granted requester for one cycle, clear gnt, and enter GAP.
REQ-029 GAP: SHALL hold cs_n high for CS_GAP cycles, ignore req, then enter IDLE; a new grant SHALL be possible in the first IDLE cycle.
REQ-030 A req bit dropping mid-frame SHALL NOT abort the frame; the frame completes and done still pulses.
REQ-031 A req bit for the granted requester still high in IDLE after GAP SHALL be treated as a new frame request.
REQ-032 pld_rd and done SHALL never be high for the non-granted requester; gnt SHALL be at most one-hot.

Reset
REQ-033 On rst high, SHALL return asynchronously to IDLE regardless of state, including mid-frame, with no done pulse and the round-robin pointer reset.
REQ-034 Reset values SHALL be: cs_n 1, tx_valid 0, tx_data 0, gnt 0, pld_rd 0, done 0, busy 0, all counters 0.

Verification
REQ-035 req=01, type0=A4, len0=2, pld0 yielding 00 then 02, tx_ready tied 1 -> cs_n falls, first tx_valid exactly 112 cycles later, bytes AA 55 A4 00 02, two pld_rd[0] pulses, done[0] after eng_busy low, cs_n high for 256 cycles.
REQ-036 req=11 held across three frames -> grants 0, 1, 0 in that order.
REQ-037 len1=0, type1=A5 -> bytes AA 55 A5 only, no pld_rd, done[1] pulses once.
REQ-038 tx_ready toggled randomly during a len=255 frame -> exactly 258 bytes transferred, tx_data stable during every stall, 255 pld_rd pulses.
REQ-039 rst asserted during PLD byte 5 of a len=10 frame -> cs_n 1 and tx_valid 0 immediately, no done pulse; a subsequent request restarts with a full 112-cycle lead.
REQ-040 req[0] dropped in HDR -> frame completes and done[0] pulses.
